// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) sequencer for a single-ported, fixed-latency
// unified memory shared by the IF and MEM pipeline stages.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              discard_q, discard_d;
    logic              wr_q, wr_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic d_pend, i_pend, last, discard_now;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        discard_d  = discard_q;
        wr_d       = wr_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // A port whose done is high this cycle has already been served.
        d_pend      = dm_req & ~dm_done_q;
        i_pend      = if_req & ~if_done_q;
        last        = (cnt_q == CNT_W'(1));
        discard_now = discard_q | if_kill;

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (d_pend) begin
                        mem_en    = 1'b1;
                        mem_wr    = dm_wr;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wr ? dm_wdata : '0;
                        wr_d      = dm_wr;
                        cnt_d     = CNT_W'(MEM_LAT);
                        state_d   = BUSY_D;
                    end else if (i_pend) begin
                        mem_en    = 1'b1;
                        mem_addr  = if_addr;
                        wr_d      = 1'b0;
                        discard_d = 1'b0;
                        cnt_d     = CNT_W'(MEM_LAT);
                        state_d   = BUSY_I;
                    end
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    if (!wr_q) dm_rdata_d = mem_rdata;
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            BUSY_I: begin
                cnt_d     = cnt_q - CNT_W'(1);
                discard_d = discard_now;
                if (last) begin
                    // A kill in the completion cycle still discards the fetch.
                    if (!discard_now) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            discard_q  <= 1'b0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_done  = if_done_q;
    assign dm_done  = dm_done_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_stall = if_req & ~if_done_q;
    assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a time-stamped
// transaction model of the shared-memory arbiter.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, dm_req, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: one outstanding access, completing at an absolute cycle.
    bit          m_busy, m_is_d, m_wr, m_kill, m_if_done, m_dm_done;
    int          m_end;
    logic [15:0] m_if_rdata, m_dm_rdata;

    task automatic model_reset();
        m_busy = 0; m_is_d = 0; m_wr = 0; m_kill = 0;
        m_if_done = 0; m_dm_done = 0; m_end = 0;
        m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    task automatic step();
        bit          issue_d, issue_i, x_en, x_wr, nid, ndd;
        logic [15:0] x_addr, x_wdata;
        #3;
        issue_d = !rst && !m_busy && dm_req && !m_dm_done;
        issue_i = !rst && !m_busy && !issue_d && if_req && !m_if_done;
        x_en    = issue_d || issue_i;
        x_wr    = issue_d && dm_wr;
        x_addr  = issue_d ? dm_addr : (issue_i ? if_addr : 16'h0);
        x_wdata = x_wr ? dm_wdata : 16'h0;

        check_eq("if_done",   16'(if_done),  16'(m_if_done));
        check_eq("dm_done",   16'(dm_done),  16'(m_dm_done));
        check_eq("if_rdata",  if_rdata,      m_if_rdata);
        check_eq("dm_rdata",  dm_rdata,      m_dm_rdata);
        check_eq("if_stall",  16'(if_stall), 16'(if_req && !m_if_done));
        check_eq("dm_stall",  16'(dm_stall), 16'(dm_req && !m_dm_done));
        check_eq("mem_en",    16'(mem_en),   16'(x_en));
        check_eq("mem_wr",    16'(mem_wr),   16'(x_wr));
        check_eq("mem_addr",  mem_addr,      x_addr);
        check_eq("mem_wdata", mem_wdata,     x_wdata);

        if (rst) begin
            model_reset();
        end else begin
            nid = 0; ndd = 0;
            if (m_busy) begin
                if (!m_is_d && if_kill) m_kill = 1;
                if (cyc == m_end) begin
                    if (m_is_d) begin
                        ndd = 1;
                        if (!m_wr) m_dm_rdata = mem_rdata;
                    end else if (!m_kill) begin
                        nid = 1;
                        m_if_rdata = mem_rdata;
                    end
                    m_busy = 0;
                    m_kill = 0;
                end
            end else if (x_en) begin
                m_busy = 1; m_is_d = issue_d; m_wr = x_wr;
                m_end = cyc + LAT; m_kill = 0;
            end
            m_if_done = nid;
            m_dm_done = ndd;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_inputs();
        rst = 0; if_req = 0; if_kill = 0; dm_req = 0; dm_wr = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    initial begin
        clear_inputs();
        mem_rdata = '0;
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        steps(2);
        rst = 0;
        check_eq("rst_if_rdata", if_rdata, 16'h0);
        check_eq("rst_dm_done", 16'(dm_done), 16'h0);
        steps(1);

        // Single fetch
        if_req = 1; if_addr = 16'h0040; mem_rdata = 16'hA5A5;
        #1 check_eq("sf_issue", 16'(mem_en), 16'h1);
        step();
        steps(4);
        check_eq("sf_done", 16'(if_done), 16'h1);
        check_eq("sf_data", if_rdata, 16'hA5A5);
        if_req = 0;
        steps(2);

        // Contention: D wins, I follows when D completes
        dm_req = 1; dm_addr = 16'h1000; if_req = 1; if_addr = 16'h0042;
        mem_rdata = 16'h1111;
        #1 check_eq("ct_addr_d", mem_addr, 16'h1000);
        steps(5);
        check_eq("ct_dm_done", 16'(dm_done), 16'h1);
        dm_req = 0;
        #1 check_eq("ct_addr_i", mem_addr, 16'h0042);
        mem_rdata = 16'h2222;
        steps(5);
        check_eq("ct_if_done", 16'(if_done), 16'h1);
        check_eq("ct_if_data", if_rdata, 16'h2222);
        if_req = 0;
        steps(2);

        // Write leaves dm_rdata alone
        dm_req = 1; dm_wr = 1; dm_addr = 16'h2000; dm_wdata = 16'h1234;
        #1;
        check_eq("wr_mem_wr", 16'(mem_wr), 16'h1);
        check_eq("wr_wdata", mem_wdata, 16'h1234);
        steps(5);
        check_eq("wr_done", 16'(dm_done), 16'h1);
        check_eq("wr_rdata", dm_rdata, 16'h1111);
        dm_req = 0; dm_wr = 0;
        steps(2);

        // Kill during an in-flight fetch
        if_req = 1; if_addr = 16'h0040; mem_rdata = 16'h3333;
        steps(2);
        if_kill = 1; if_addr = 16'h0080;
        step();
        if_kill = 0;
        steps(2);
        check_eq("kl_no_done", 16'(if_done), 16'h0);
        #1 check_eq("kl_reissue", mem_addr, 16'h0080);
        mem_rdata = 16'h4444;
        steps(5);
        check_eq("kl_done", 16'(if_done), 16'h1);
        check_eq("kl_data", if_rdata, 16'h4444);
        if_req = 0;
        steps(2);

        // Reset mid-access
        dm_req = 1; dm_addr = 16'h3000; mem_rdata = 16'h0;
        steps(2);
        rst = 1; dm_req = 0;
        step();
        rst = 0; mem_rdata = 16'hBEEF;
        check_eq("rm_rdata", dm_rdata, 16'h0);
        steps(4);
        check_eq("rm_no_cap", dm_rdata, 16'h0);
        dm_req = 1; mem_rdata = 16'h5555;
        steps(5);
        check_eq("rm_new_done", 16'(dm_done), 16'h1);
        check_eq("rm_new_data", dm_rdata, 16'h5555);

        // Held request through its done cycle is not re-issued
        #1 check_eq("hd_no_reissue", 16'(mem_en), 16'h0);
        step();
        dm_req = 0;
        steps(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (if_req && !m_if_done) begin
                if_kill = ($urandom_range(0, 7) == 0);
                if (if_kill) if_addr = 16'($urandom);
            end else begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = 16'($urandom);
                if_kill = ($urandom_range(0, 15) == 0);
            end
            if (!(dm_req && !m_dm_done)) begin
                dm_req   = 1'($urandom_range(0, 1));
                dm_wr    = 1'($urandom_range(0, 1));
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
            mem_rdata = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Fixed-priority arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data-memory port of the 16-bit pipelined processor. It accepts one request at a time, counts out the memory latency, captures read data, and returns a one-cycle done pulse plus a stall level to the requesting stage. It sits between the IF/MEM pipeline stages and the memory, alongside the hazard detection unit. It honours fetch kills on taken branches.

## Interface
- MEM_LAT, 4, cycles from the issue cycle to the cycle `mem_rdata` is valid; legal range 1 to 15.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_done`.
- if_addr  in  ADDR_W  fetch address; stable while `if_req` is high.
- if_kill  in  1  discards the in-flight fetch (taken branch or flush).
- if_rdata  out  DATA_W  fetched instruction; registered, held between captures.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_stall  out  1  equals `if_req & ~if_done`.
- dm_req  in  1  data request, read or write; held until `dm_done`.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  load data; registered, held between captures.
- dm_done  out  1  one-cycle pulse: data access complete.
- dm_stall  out  1  equals `dm_req & ~dm_done`.
- mem_en  out  1  issue strobe, high for exactly one cycle per access.
- mem_wr  out  1  write qualifier for `mem_en`.
- mem_addr  out  ADDR_W  access address; 0 when `mem_en` is 0.
- mem_wdata  out  DATA_W  write data; 0 when `mem_en` is 0 or `mem_wr` is 0.
- mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the issue cycle.

## Operation
- The FSM has three states: IDLE, BUSY_D and BUSY_I. A down-counter of width clog2(MEM_LAT+1) runs alongside it, plus a discard flag.
- **IDLE, issuing:**
  - When a request is pending, the arbiter issues it this cycle. `mem_en`, `mem_wr`, `mem_addr` and `mem_wdata` are driven combinationally from the winning port.
  - The counter is loaded with MEM_LAT.
  - Next state is BUSY_D or BUSY_I.
- **Priority:** D beats I when both request in the same cycle, because D belongs to the older instruction. Any pending I request issues when D completes.
- **Same-side re-issue:** in the cycle a port's done is high, that port's req is treated as already satisfied and is not issued. The other port may issue in that same cycle.
- **BUSY_x:**
  - The counter decrements each cycle.
  - In the cycle it reaches 1, the arbiter captures `mem_rdata` into `x_rdata`. Reads only; a write leaves `dm_rdata` unchanged.
  - It then sets done for the next cycle and returns to IDLE.
  - The memory is never re-issued while busy.
- **Kill:**
  - `if_kill` during BUSY_I sets the discard flag. The memory access still runs to completion.
  - At completion a discarded fetch does not update `if_rdata`, does not pulse `if_done`, and clears the flag.
  - `if_kill` in IDLE, BUSY_D, or the `if_done` cycle has no effect on the arbiter.
- **Reset:**
  - `if_done`, `dm_done`, `mem_en` and `mem_wr` are 0.
  - `if_rdata`, `dm_rdata`, `mem_addr` and `mem_wdata` are 0.
  - State is IDLE, counter is 0, discard flag is 0.
  - After reset, `if_stall` and `dm_stall` follow their req inputs.
- **Reset mid-access:** the in-flight access is abandoned. A `mem_rdata` value arriving afterwards is ignored and no done pulses for it.

## Timing
- Cycle t0 is the issue cycle (IDLE, `mem_en` = 1).
- `mem_rdata` is valid and captured at t0+MEM_LAT.
- Done pulses at t0+MEM_LAT+1, with rdata valid from that cycle on.
- Request-to-done latency is MEM_LAT+1 cycles for an uncontended request.
- Back-to-back: the other port's request issues at t0+MEM_LAT+1, so memory throughput is one access per MEM_LAT+1 cycles.
- Stall outputs are combinational from registered done and the req inputs. There is no combinational path from `mem_rdata` to any output.
- A requester never sees a done pulse without a prior req. Done never pulses for two consecutive cycles on the same port.

## Test plan
All scenarios use MEM_LAT = 4.
- **Single fetch:** release reset, then `if_req`=1 with `if_addr`=0x0040 at t0, and memory returns 0xA5A5 at t0+4 -> `mem_en`=1 only at t0; `if_stall`=1 t0..t0+4; `if_done`=1 only at t0+5; `if_rdata`=0xA5A5.
- **Contention:** `dm_req` read 0x1000 and `if_req` 0x0042 both at t0 -> D issued at t0 with `dm_done` at t0+5; I issued at t0+5 with `if_done` at t0+10; `if_stall` high t0..t0+9.
- **Write:** `dm_wr`=1, `dm_addr`=0x2000, `dm_wdata`=0x1234 at t0 -> at t0 `mem_en`=1, `mem_wr`=1, `mem_addr`=0x2000, `mem_wdata`=0x1234; `dm_done` at t0+5; `dm_rdata` keeps its previous value.
- **Kill:** fetch of 0x0040 issued at t0, `if_kill` pulsed at t0+2, `if_addr` changed to 0x0080 -> no `if_done` at t0+5; 0x0080 issued at t0+5; `if_done` at t0+10 with the new data.
- **Reset mid-access:** `dm_req` read issued at t0, `rst` at t0+2 -> all outputs 0 at t0+3; the 0xBEEF returned at t0+4 is not captured; `dm_done` stays 0 until a new post-reset request completes.
- **Held request:** `dm_req` held high through the `dm_done` cycle at t0+5 and dropped at t0+6 -> no second `mem_en` at t0+5.
